// File: rtl/qpsk_mapper.sv
// QPSK symbol mapper: splits each input word into DATA_WIDTH/2 bit pairs, MSB pair first,
// and emits one signed I/Q sample per pair on an AXI-Stream-style output.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no word held; s_tready=1 (outside reset), m_tvalid=0
// S_ACTIVE | word held; m_tvalid=1, presenting the symbol at r_idx
module qpsk_mapper #(
  parameter int DATA_WIDTH = 32,
  parameter int IQ_WIDTH   = 16,
  parameter int AMP        = 23170
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      s_tdata,
  input  logic                       s_tvalid,
  input  logic                       s_tlast,
  output logic                       s_tready,
  output logic signed [IQ_WIDTH-1:0] m_i,
  output logic signed [IQ_WIDTH-1:0] m_q,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast
);

  localparam int NSYM  = DATA_WIDTH / 2;
  localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);
  localparam logic signed [IQ_WIDTH-1:0] POS_AMP = IQ_WIDTH'(AMP);
  localparam logic signed [IQ_WIDTH-1:0] NEG_AMP = -POS_AMP;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_last;
  logic [IDX_W-1:0]      r_idx;

  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_word_nxt;
  logic                  w_last_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  w_active;
  logic                  w_at_last;

  assign w_active  = (r_state == S_ACTIVE);
  assign w_at_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_last  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_last  <= w_last_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_last_nxt  = r_last;
    w_idx_nxt   = r_idx;
    s_tready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // rst gates ready so upstream sees no acceptance while reset is asserted
        s_tready = rst;
        if (s_tvalid) begin
          w_word_nxt  = s_tdata;
          w_last_nxt  = s_tlast;
          w_idx_nxt   = '0;
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        s_tready = rst & m_tready & w_at_last;
        if (m_tready) begin
          if (!w_at_last) begin
            w_word_nxt = {r_word[DATA_WIDTH-3:0], 2'b00};
            w_idx_nxt  = r_idx + IDX_W'(1);
          end else if (s_tvalid) begin
            w_word_nxt = s_tdata;
            w_last_nxt = s_tlast;
            w_idx_nxt  = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The current symbol always sits in the top two bits of the held word
  assign m_tvalid = w_active;
  assign m_i      = !w_active ? '0 : (r_word[DATA_WIDTH-2] ? NEG_AMP : POS_AMP);
  assign m_q      = !w_active ? '0 : (r_word[DATA_WIDTH-1] ? NEG_AMP : POS_AMP);
  assign m_tlast  = w_active & r_last & w_at_last;

endmodule

// File: tb/tb_qpsk_mapper.sv
// Directed bench for qpsk_mapper: single word, back-to-back, backpressure,
// starvation/restart and asynchronous mid-word reset.
module tb_qpsk_mapper;

  localparam int A = 23170;

  logic               clk;
  logic               rst;
  logic [31:0]        s_tdata;
  logic               s_tvalid;
  logic               s_tlast;
  logic               s_tready;
  logic signed [15:0] m_i;
  logic signed [15:0] m_q;
  logic               m_tvalid;
  logic               m_tready;
  logic               m_tlast;

  int tests_run    = 0;
  int tests_failed = 0;

  qpsk_mapper #(.DATA_WIDTH(32), .IQ_WIDTH(16), .AMP(A)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_i(m_i), .m_q(m_q), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_i(input logic [31:0] w, input int k);
    logic [31:0] b;
    b = w >> (30 - 2 * k);
    return b[0] ? -A : A;
  endfunction

  function automatic int exp_q(input logic [31:0] w, input int k);
    logic [31:0] b;
    b = w >> (30 - 2 * k);
    return b[1] ? -A : A;
  endfunction

  // Checks the 16 symbols of word w (called at the negedge after acceptance);
  // reprograms the upstream inputs at k==0 and optionally stalls at stall_at.
  task automatic symbols(input logic [31:0] w, input bit tl,
                         input logic [31:0] nd, input bit ntl, input bit nv,
                         input int stall_at, input int stall_n);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("valid_k%0d", k), int'(m_tvalid), 1);
      chk($sformatf("i_k%0d", k), int'(m_i), exp_i(w, k));
      chk($sformatf("q_k%0d", k), int'(m_q), exp_q(w, k));
      chk($sformatf("tlast_k%0d", k), int'(m_tlast), (tl && k == 15) ? 1 : 0);
      chk($sformatf("sready_k%0d", k), int'(s_tready), (k == 15) ? 1 : 0);
      if (k == 0) begin
        s_tdata  = nd;
        s_tlast  = ntl;
        s_tvalid = nv;
      end
      if (k == stall_at) begin
        m_tready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          chk($sformatf("stall_valid_%0d", s), int'(m_tvalid), 1);
          chk($sformatf("stall_i_%0d", s), int'(m_i), exp_i(w, k));
          chk($sformatf("stall_q_%0d", s), int'(m_q), exp_q(w, k));
          chk($sformatf("stall_sready_%0d", s), int'(s_tready), 0);
          chk($sformatf("stall_tlast_%0d", s), int'(m_tlast), 0);
        end
        m_tready = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_valid", int'(m_tvalid), 0);
    chk("rst_tlast", int'(m_tlast), 0);
    chk("rst_i", int'(m_i), 0);
    chk("rst_q", int'(m_q), 0);
    chk("rst_sready", int'(s_tready), 0);
    rst = 1'b1;
    #1;
    chk("idle_sready", int'(s_tready), 1);
    chk("idle_valid", int'(m_tvalid), 0);

    // single word
    @(negedge clk);
    s_tdata  = 32'h1B00_0000;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    @(negedge clk);
    symbols(32'h1B00_0000, 1'b1, 32'h0, 1'b0, 1'b0, 99, 0);
    chk("single_end_valid", int'(m_tvalid), 0);
    chk("single_end_sready", int'(s_tready), 1);

    // back-to-back: three words, no gap between them
    s_tdata  = 32'h0123_4567;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    @(negedge clk);
    symbols(32'h0123_4567, 1'b0, 32'h89AB_CDEF, 1'b0, 1'b1, 99, 0);
    symbols(32'h89AB_CDEF, 1'b0, 32'hFFFF_0000, 1'b1, 1'b1, 99, 0);
    symbols(32'hFFFF_0000, 1'b1, 32'h0, 1'b0, 1'b0, 99, 0);
    chk("b2b_end_valid", int'(m_tvalid), 0);

    // backpressure at index 7 for 5 cycles
    s_tdata  = 32'hFFFF_FFFF;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    @(negedge clk);
    symbols(32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0, 1'b0, 7, 5);
    chk("bp_end_valid", int'(m_tvalid), 0);

    // starvation then restart at index 0
    @(negedge clk);
    chk("starve_valid", int'(m_tvalid), 0);
    chk("starve_sready", int'(s_tready), 1);
    s_tdata  = 32'hE400_0000;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    @(negedge clk);
    symbols(32'hE400_0000, 1'b1, 32'h0, 1'b0, 1'b0, 99, 0);
    chk("restart_end_valid", int'(m_tvalid), 0);

    // asynchronous reset at index 5
    s_tdata  = 32'h1B1B_1B1B;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_i", int'(m_i), -A);
    chk("pre_rst_q", int'(m_q), A);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", int'(m_tvalid), 0);
    chk("async_rst_i", int'(m_i), 0);
    chk("async_rst_q", int'(m_q), 0);
    chk("async_rst_sready", int'(s_tready), 0);
    chk("async_rst_tlast", int'(m_tlast), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_sready", int'(s_tready), 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_valid_%0d", c), int'(m_tvalid), 0);
    end
    s_tdata  = 32'h0000_0003;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    @(negedge clk);
    symbols(32'h0000_0003, 1'b1, 32'h0, 1'b0, 1'b0, 99, 0);
    chk("final_valid", int'(m_tvalid), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/qpsk_mapper.md
QPSK_MAPPER -- requirements
Module: qpsk_mapper

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the input word width; it SHALL be even and at least 4.
REQ-002 The block SHALL have parameter IQ_WIDTH, default 16, giving the signed I/Q sample width.
REQ-003 The block SHALL have parameter AMP, default 23170, giving the positive constellation amplitude (0.707 full scale); AMP SHALL be less than 2^(IQ_WIDTH-1).
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL change on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port s_tdata, input, DATA_WIDTH bits: input word (BRAM data).
REQ-007 Port s_tvalid, input, 1 bit: input word valid.
REQ-008 Port s_tlast, input, 1 bit: input word is the last of the frame.
REQ-009 Port s_tready, output, 1 bit: the block accepts a word this cycle.
REQ-010 Port m_i, output, IQ_WIDTH bits, signed: in-phase sample.
REQ-011 Port m_q, output, IQ_WIDTH bits, signed: quadrature sample.
REQ-012 Port m_tvalid, output, 1 bit: the I/Q sample is valid.
REQ-013 Port m_tready, input, 1 bit: the downstream stage accepts the sample.
REQ-014 Port m_tlast, output, 1 bit: the sample is the final symbol of the frame.

Function
REQ-015 An input transfer SHALL occur on a rising edge where s_tvalid and s_tready are both 1; an output transfer SHALL occur on a rising edge where m_tvalid and m_tready are both 1.
REQ-016 Each word SHALL produce NSYM = DATA_WIDTH/2 symbols, taken MSB pair first: bits [DATA_WIDTH-1:DATA_WIDTH-2] first and bits [1:0] last.
REQ-017 Mapping for symbol bits b1b0: m_i = +AMP when b0=0 and -AMP when b0=1; m_q = +AMP when b1=0 and -AMP when b1=1.
REQ-018 The block SHALL have exactly two states, IDLE (no word held) and ACTIVE (word held; m_tvalid=1).
REQ-019 In IDLE: s_tready=1 and m_tvalid=0; an input transfer SHALL load the word and s_tlast into holding registers, clear the symbol index to 0, and move to ACTIVE.
REQ-020 Latency: the first symbol of an accepted word SHALL be presented with m_tvalid=1 in the cycle after the input transfer.
REQ-021 In ACTIVE, an output transfer with symbol index < NSYM-1 SHALL advance the index by 1 (shift the held word by 2 bits).
REQ-022 In ACTIVE: s_tready = m_tready AND (index == NSYM-1); this is the only combinational input-to-output path.
REQ-023 On an output transfer at index NSYM-1 with s_tvalid=1, the block SHALL load the new word, set the index to 0 and stay in ACTIVE, so that there is no bubble between words.
REQ-024 On an output transfer at index NSYM-1 with s_tvalid=0, the block SHALL return to IDLE.
REQ-025 m_tlast SHALL be 1 only when m_tvalid=1, the held tlast flag is 1, and index == NSYM-1.
REQ-026 While m_tvalid=1 and m_tready=0, m_i, m_q, m_tlast and m_tvalid SHALL hold their values; s_tdata SHALL be ignored.
REQ-027 Once asserted, m_tvalid SHALL NOT deassert until an output transfer occurs, except on reset.
REQ-028 m_i, m_q and m_tlast SHALL be driven only from registered state.

Reset
REQ-029 While rst=0, the block SHALL be forced immediately (without waiting for a clock edge) to: state IDLE, m_tvalid=0, m_tlast=0, m_i=0, m_q=0, index 0, holding registers 0, and s_tready=0.
REQ-030 A reset asserted mid-word SHALL discard the remaining symbols; after release, the first rising edge SHALL be in IDLE with s_tready=1.

Verification
REQ-031 Single word test: s_tdata=0x1B000000, s_tlast=1, m_tready=1 held high.
  - Required response: 16 symbols on consecutive cycles, starting the cycle after acceptance.
  - The first four symbols SHALL be (I,Q) = (+23170,+23170), (-23170,+23170), (+23170,-23170), (-23170,-23170).
  - The remaining 12 symbols SHALL be (+23170,+23170).
  - m_tlast SHALL be 1 only on the 16th symbol.
REQ-032 Back-to-back test: 3 words with s_tvalid held high and m_tready=1.
  - Required response: 48 consecutive valid cycles with no gap.
  - s_tready SHALL pulse only at index 15.
REQ-033 Backpressure test: m_tready=0 for 5 cycles at index 7 of word 0xFFFFFFFF.
  - Required response: (-23170,-23170) held for those cycles, with m_tvalid=1 and the index not advancing.
  - s_tready SHALL stay 0.
REQ-034 Starvation test: s_tvalid=0 after the last symbol.
  - Required response: state returns to IDLE and m_tvalid=0 on the next cycle.
  - A later word SHALL restart at index 0.
REQ-035 Reset mid-word test: rst=0 asserted asynchronously at index 5.
  - Required response: m_tvalid=0 and m_i=m_q=0 before the next clock edge.
  - After release, s_tready=1 and no stale symbols are emitted.
